// File: rtl/sar_search.sv
// Successive-approximation search: drives trial operands to an external
// comparator and resolves the hidden target MSB first.
module sar_search #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             gt_i,
   input  logic             eq_i,
   input  logic             lt_i,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             exact,
   output logic             err
);

   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   logic [PW-1:0]    ptr;
   logic [WIDTH-1:0] cur_bit;
   logic [WIDTH-1:0] nxt_bit;
   logic [WIDTH-1:0] msb_bit;
   logic             one_hot;

   always_comb begin
      cur_bit = WIDTH'(1) << ptr;
      nxt_bit = cur_bit >> 1;
      msb_bit = {1'b1, {(WIDTH-1){1'b0}}};
      // odd parity excluding all-three-high means exactly one is set
      one_hot = (gt_i ^ eq_i ^ lt_i) & ~(gt_i & eq_i & lt_i);
   end

   assign busy = (state == SEARCH);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         trial  <= '0;
         result <= '0;
         exact  <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               trial <= '0;
               if (start) begin
                  trial <= msb_bit;
                  ptr   <= PW'(WIDTH-1);
                  err   <= 1'b0;
                  exact <= 1'b0;
                  state <= SEARCH;
               end
            end
            SEARCH: begin
               if (!one_hot) begin
                  err    <= 1'b1;
                  result <= trial;
                  exact  <= 1'b0;
                  state  <= DONE;
               end else if (eq_i) begin
                  result <= trial;
                  exact  <= 1'b1;
                  state  <= DONE;
               end else if (ptr == '0) begin
                  result <= gt_i ? (trial & ~WIDTH'(1)) : trial;
                  exact  <= 1'b0;
                  state  <= DONE;
               end else begin
                  trial <= (gt_i ? (trial & ~cur_bit) : trial) | nxt_bit;
                  ptr   <= ptr - PW'(1);
               end
            end
            DONE: begin
               trial <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: behavioural comparator + search model, per-cycle
// compare, directed scenarios with literal expectations, random traffic.
module tb_sar_search;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         gt_i, eq_i, lt_i;
   logic [W-1:0] trial, result;
   logic         busy, done, exact, err;

   int target = 0;
   int fault_step = -1;
   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   sar_search #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .gt_i   (gt_i),
      .eq_i   (eq_i),
      .lt_i   (lt_i),
      .trial  (trial),
      .busy   (busy),
      .done   (done),
      .result (result),
      .exact  (exact),
      .err    (err)
   );

   // model: search number, step within search, phase 0 idle/1 search/2 done
   int m_phase = 0;
   int m_step = 0;
   int m_k = 0;
   int m_tgt = 0;
   int m_res = 0;
   bit m_fl = 1'b0;
   bit m_ex = 1'b0;
   bit m_er = 1'b0;
   logic flt;

   // i-th trial: target prefix above the probed bit, probed bit set, rest 0
   function automatic int trial_at(int t, int i);
      return ((t >> (W - i)) << (W - i)) | (1 << (W - 1 - i));
   endfunction

   // honest search ends when the trial hits target's lowest set bit
   function automatic int k_of(int t);
      int c;
      if (t == 0) return W;
      c = 0;
      while (((t >> c) & 1) == 0) c++;
      return W - c;
   endfunction

   function automatic bit fault_hit(int t, int f);
      return (f >= 0) && (f < k_of(t));
   endfunction

   function automatic int k_eff(int t, int f);
      return fault_hit(t, f) ? f + 1 : k_of(t);
   endfunction

   assign flt  = (m_phase == 1) && (m_step == fault_step);
   assign gt_i = flt | (int'(trial) > target);
   assign lt_i = flt | (int'(trial) < target);
   assign eq_i = !flt && (int'(trial) == target);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_step  <= 0;
         m_res   <= 0;
         m_ex    <= 1'b0;
         m_er    <= 1'b0;
      end else begin
         case (m_phase)
            0: if (start) begin
               m_tgt   <= target;
               m_k     <= k_eff(target, fault_step);
               m_fl    <= fault_hit(target, fault_step);
               m_phase <= 1;
               m_step  <= 0;
               m_ex    <= 1'b0;
               m_er    <= 1'b0;
            end
            1: if (m_step == m_k - 1) begin
               m_phase <= 2;
               m_er    <= m_fl;
               m_ex    <= !m_fl && (m_tgt != 0);
               m_res   <= m_fl ? trial_at(m_tgt, m_step) : m_tgt;
            end else begin
               m_step <= m_step + 1;
            end
            default: m_phase <= 0;
         endcase
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("trial", int'(trial),
             (m_phase == 0) ? 0 : trial_at(m_tgt, m_step));
         chk("busy", int'(busy), int'(m_phase == 1));
         chk("done", int'(done), int'(m_phase == 2));
         chk("result", int'(result), m_res);
         chk("exact", int'(exact), int'(m_ex));
         chk("err", int'(err), int'(m_er));
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_trial"}, int'(trial), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_result"}, int'(result), 0);
      chk({tag, "_exact"}, int'(exact), 0);
      chk({tag, "_err"}, int'(err), 0);
   endtask

   // exp_seq packs the trials seen while busy, one nibble each, oldest first
   task automatic run_search(input int tgt, input int fst, input int exp_res,
                             input int exp_ex, input int exp_er,
                             input int exp_lat, input int exp_seq,
                             input bit mid);
      int edges;
      int n;
      int seq;
      bit ok;
      @(negedge clk);
      #1;
      target = tgt;
      fault_step = fst;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 1;
      n = 0;
      seq = 0;
      ok = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) begin
            n++;
            seq = (seq << 4) | int'(trial);
         end
         start = (mid && n == 2);
         @(posedge clk);
         edges++;
      end
      start = 1'b0;
      chk("done_seen", int'(ok), 1);
      chk("latency", edges, exp_lat);
      chk("busy_cycles", n, exp_lat - 1);
      chk("trial_seq", seq, exp_seq);
      chk("lit_result", int'(result), exp_res);
      chk("lit_exact", int'(exact), exp_ex);
      chk("lit_err", int'(err), exp_er);
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;

      run_search(0, -1, 0, 0, 0, 5, 'h8421, 1'b0);
      run_search(15, -1, 15, 1, 0, 5, 'h8CEF, 1'b0);
      run_search(8, -1, 8, 1, 0, 2, 'h8, 1'b0);
      run_search(5, -1, 5, 1, 0, 5, 'h8465, 1'b1);
      run_search(3, 1, 4, 0, 1, 3, 'h84, 1'b0);
      run_search(6, -1, 6, 1, 0, 4, 'h846, 1'b0);

      // abort a search asynchronously while trial is 12
      @(negedge clk);
      #1;
      target = 15;
      fault_step = -1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ok = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (trial == 4'd12) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reach_12", int'(ok), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      run_search(10, -1, 10, 1, 0, 4, 'h8CA, 1'b0);

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         #1;
         if (m_phase == 0) begin
            target = int'($urandom_range(0, 15));
            fault_step = ($urandom_range(0, 4) == 0) ?
                         int'($urandom_range(0, 3)) : -1;
         end
         start = ($urandom_range(0, 2) != 0);
      end
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
